// File: rtl/proc_pkg.sv
// Shared definitions for the two-stage processor: default widths, the NOP word
// and the fetch-stage state encoding.
package proc_pkg;

    localparam int          DBITS_DEF   = 32;
    localparam int          IMEM_AW_DEF = 8;
    localparam logic [31:0] NOP_WORD    = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifex_reg.sv
// IF/EX pipeline register with hold and squash controls.
// load=1 captures the fetch PC fields; squash=1 forces a NOP bubble in place of the instruction.
module ifex_reg
    import proc_pkg::*;
#(
    parameter int          DBITS = DBITS_DEF,
    parameter logic [31:0] NOP   = NOP_WORD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             squash,
    input  logic [31:0]      next_inst,
    input  logic [DBITS-1:0] next_pc,
    output logic [31:0]      inst,
    output logic [DBITS-1:0] pc,
    output logic [DBITS-1:0] pcplus4,
    output logic             valid
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst    <= NOP;
            pc      <= '0;
            pcplus4 <= '0;
            valid   <= 1'b0;
        end else begin
            if (load) begin
                pc      <= next_pc;
                pcplus4 <= next_pc + DBITS'(4);
            end
            // A squash wins over a load so redirects still record the squashed slot's PC.
            if (squash) begin
                inst  <= NOP;
                valid <= 1'b0;
            end else if (load) begin
                inst  <= next_inst;
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and feeds the
// IF/EX register. Handles PLL-lock boot, stall, redirect with squash and halt.
module fetch_stage
    import proc_pkg::*;
#(
    parameter int               DBITS    = DBITS_DEF,
    parameter int               IMEM_AW  = IMEM_AW_DEF,
    parameter logic [DBITS-1:0] START_PC = '0,
    parameter logic [31:0]      NOP      = NOP_WORD
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pll_locked,
    input  logic               stall,
    input  logic               redirect,
    input  logic [DBITS-1:0]   redirect_pc,
    input  logic               halt,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    output logic [DBITS-1:0]   pc_out,
    output logic [31:0]        ifex_inst,
    output logic [DBITS-1:0]   ifex_pc,
    output logic [DBITS-1:0]   ifex_pcplus4,
    output logic               ifex_valid,
    output logic               align_err,
    output logic               halted,
    output fetch_state_e       state
);

    logic [DBITS-1:0] pc_q;
    logic             run;
    logic             do_halt;
    logic             do_redirect;
    logic             do_fetch;
    logic             reg_load;
    logic             reg_squash;

    assign pc_out    = pc_q;
    assign imem_addr = pc_q[IMEM_AW+1:2];

    // Per-edge priority in RUN: halt > redirect > stall > normal fetch.
    always_comb begin
        run         = (state == RUN);
        do_halt     = run && halt;
        do_redirect = run && !halt && redirect;
        do_fetch    = run && !halt && !redirect && !stall;
        reg_load    = do_redirect || do_fetch;
        reg_squash  = do_halt || do_redirect;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= BOOT;
            pc_q      <= START_PC;
            align_err <= 1'b0;
            halted    <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    if (pll_locked) state <= RUN;
                end
                RUN: begin
                    if (halt) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (redirect) begin
                        pc_q <= {redirect_pc[DBITS-1:2], 2'b00};
                        if (redirect_pc[1:0] != 2'b00) align_err <= 1'b1;
                    end else if (!stall) begin
                        pc_q <= pc_q + DBITS'(4);
                    end
                end
                HALT: begin
                    // Only reset leaves HALT.
                end
                default: state <= BOOT;
            endcase
        end
    end

    ifex_reg #(
        .DBITS (DBITS),
        .NOP   (NOP)
    ) u_ifex_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (reg_load),
        .squash    (reg_squash),
        .next_inst (imem_data),
        .next_pc   (pc_q),
        .inst      (ifex_inst),
        .pc        (ifex_pc),
        .pcplus4   (ifex_pcplus4),
        .valid     (ifex_valid)
    );

endmodule
